noc_inject_if: RTL



---
 rtl/noc_pkg.sv | 44 ++++
 rtl/noc_sync_fifo.sv | 73 +++++++
 rtl/noc_inject_if.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC injection interface: FSM encoding,
// flit field layout helpers and the VC index width calculation.
package noc_pkg;

    // Packet framing state of the injection interface
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OPEN = 1'b1
    } inj_state_e;

    // Default parameter values used by the block and its bench
    localparam int DEF_FLIT_DATA_WIDTH = 32;
    localparam int DEF_NUM_VCS         = 2;
    localparam int DEF_DEST_BITS       = 5;
    localparam int DEF_VC_BUF_DEPTH    = 8;
    localparam int DEF_FIFO_DEPTH      = 4;

    // A single VC still needs a one-bit VC field on the wire
    function automatic int calc_vc_bits(input int num_vcs);
        return (num_vcs <= 1) ? 1 : $clog2(num_vcs);
    endfunction

    // Flit layout from MSB: {valid, tail, dest, vc, data}
    function automatic int flit_width(input int data_w, input int dest_w, input int vc_w);
        return 2 + data_w + dest_w + vc_w;
    endfunction

    function automatic int vc_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int dest_lsb(input int data_w, input int vc_w);
        return data_w + vc_w;
    endfunction

    function automatic int tail_pos(input int data_w, input int dest_w, input int vc_w);
        return data_w + vc_w + dest_w;
    endfunction

    function automatic int valid_pos(input int data_w, input int dest_w, input int vc_w);
        return data_w + vc_w + dest_w + 1;
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock staging FIFO with an occupancy counter. A push into a full
// FIFO is refused even when a pop happens on the same edge.
module noc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointer wrap and occupancy bookkeeping for this edge
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and counter registers; reset empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/noc_inject_if.sv
// Node-to-network injection interface: frames words into flits, stages them
// in a FIFO and releases them in order as per-VC downstream credits allow.
module noc_inject_if
    import noc_pkg::*;
#(
    parameter int FLIT_DATA_WIDTH = DEF_FLIT_DATA_WIDTH,
    parameter int NUM_VCS         = DEF_NUM_VCS,
    parameter int DEST_BITS       = DEF_DEST_BITS,
    parameter int VC_BUF_DEPTH    = DEF_VC_BUF_DEPTH,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
    localparam int VC_BITS        = calc_vc_bits(NUM_VCS),
    localparam int FLIT_W         = flit_width(FLIT_DATA_WIDTH, DEST_BITS, VC_BITS)
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FLIT_DATA_WIDTH-1:0] in_data,
    input  logic [DEST_BITS-1:0]       in_dest,
    input  logic [VC_BITS-1:0]         in_vc,
    input  logic                       in_last,
    output logic [FLIT_W-1:0]          flit_out,
    output logic                       flit_en,
    input  logic [VC_BITS:0]           credit_in,
    output logic [NUM_VCS-1:0]         credit_avail,
    output logic                       credit_err,
    output logic                       busy
);

    localparam int ENTRY_W = FLIT_W - 1;
    localparam int CRED_W  = $clog2(VC_BUF_DEPTH + 1);
    localparam int VC_SPAN = 2 ** VC_BITS;
    localparam int VC_LSB  = vc_lsb(FLIT_DATA_WIDTH);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(VC_BUF_DEPTH);

    inj_state_e              state_q, state_d;
    logic [DEST_BITS-1:0]    dest_lat_q, dest_lat_d;
    logic [VC_BITS-1:0]      vc_lat_q, vc_lat_d;
    logic [CRED_W-1:0]       credit_q [NUM_VCS];
    logic [CRED_W-1:0]       credit_d [NUM_VCS];
    logic                    credit_err_q, credit_err_d;
    logic [FLIT_W-1:0]       flit_out_q, flit_out_d;

    logic                    fifo_push;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [ENTRY_W-1:0]      push_entry;
    logic [ENTRY_W-1:0]      head_entry;
    logic [DEST_BITS-1:0]    entry_dest;
    logic [VC_BITS-1:0]      entry_vc;
    logic [VC_BITS-1:0]      head_vc;
    logic [VC_SPAN-1:0]      avail_pad;
    logic                    send;
    logic                    ret_valid;
    logic [VC_BITS-1:0]      ret_vc;
    logic [NUM_VCS-1:0]      dec_vec;
    logic [NUM_VCS-1:0]      inc_vec;

    assign in_ready   = !fifo_full;
    assign fifo_push  = in_valid && in_ready;
    assign entry_dest = (state_q == IDLE) ? in_dest : dest_lat_q;
    assign entry_vc   = (state_q == IDLE) ? in_vc : vc_lat_q;
    assign push_entry = {in_last, entry_dest, entry_vc, in_data};
    assign head_vc    = head_entry[VC_LSB +: VC_BITS];
    assign ret_valid  = credit_in[VC_BITS];
    assign ret_vc     = credit_in[VC_BITS-1:0];
    assign send       = !fifo_empty && avail_pad[head_vc];

    assign flit_out   = flit_out_q;
    assign flit_en    = flit_out_q[FLIT_W-1];
    assign credit_err = credit_err_q;
    assign busy       = (state_q == OPEN) || !fifo_empty;

    noc_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (send),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Per-VC credit availability, padded so any VC code can index it safely
    always_comb begin
        avail_pad = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            credit_avail[v] = (credit_q[v] != '0);
            avail_pad[v]    = (credit_q[v] != '0);
        end
    end

    // Which VC counters see a send or a returned credit this edge
    always_comb begin
        dec_vec = '0;
        inc_vec = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            dec_vec[v] = send && (head_vc == VC_BITS'(v));
            inc_vec[v] = ret_valid && (ret_vc == VC_BITS'(v));
        end
    end

    // Credit counter update; an overflowing return holds and flags an error
    always_comb begin
        credit_err_d = credit_err_q;
        for (int v = 0; v < NUM_VCS; v++) begin
            credit_d[v] = credit_q[v];
            if (dec_vec[v] && !inc_vec[v]) begin
                credit_d[v] = credit_q[v] - 1'b1;
            end else if (inc_vec[v] && !dec_vec[v]) begin
                if (credit_q[v] == CRED_MAX) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + 1'b1;
                end
            end
        end
    end

    // Packet framing FSM and head-word dest/vc latch
    always_comb begin
        state_d    = state_q;
        dest_lat_d = dest_lat_q;
        vc_lat_d   = vc_lat_q;
        if (fifo_push) begin
            case (state_q)
                IDLE: begin
                    dest_lat_d = in_dest;
                    vc_lat_d   = in_vc;
                    if (!in_last) begin
                        state_d = OPEN;
                    end
                end
                OPEN: begin
                    if (in_last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outgoing flit: the popped head with valid set, otherwise all-zero
    always_comb begin
        flit_out_d = '0;
        if (send) begin
            flit_out_d = {1'b1, head_entry};
        end
    end

    // State, latch, credit and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            dest_lat_q   <= '0;
            vc_lat_q     <= '0;
            credit_err_q <= 1'b0;
            flit_out_q   <= '0;
            for (int v = 0; v < NUM_VCS; v++) begin
                credit_q[v] <= CRED_MAX;
            end
        end else begin
            state_q      <= state_d;
            dest_lat_q   <= dest_lat_d;
            vc_lat_q     <= vc_lat_d;
            credit_err_q <= credit_err_d;
            flit_out_q   <= flit_out_d;
            for (int v = 0; v < NUM_VCS; v++) begin
                credit_q[v] <= credit_d[v];
            end
        end
    end

endmodule
